mem_arbiter: RTL and testbench

//  Shares one byte-wide, single-port synchronous memory between the CPU's instruction

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one byte-wide synchronous memory,
// splitting each 16-bit access into two little-endian byte cycles.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [15:0]       if_rdata,
    output logic              if_ack,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic              ls_word,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [15:0]       ls_wdata,
    output logic [15:0]       ls_rdata,
    output logic              ls_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        PH0,
        PH1,
        CAP,
        ACK
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    state_t            state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic              cur_port, cur_port_nxt;
    logic              cur_we, cur_we_nxt;
    logic              cur_word, cur_word_nxt;
    logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
    logic [15:0]       cur_wdata, cur_wdata_nxt;
    logic [7:0]        lo_byte, lo_byte_nxt;

    logic              mem_en_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [7:0]        mem_wdata_nxt;
    logic [15:0]       if_rdata_nxt, ls_rdata_nxt;
    logic              if_ack_nxt, ls_ack_nxt;

    logic              grant_ls;
    logic [15:0]       cap_word;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= PORT_IF;
            cur_port   <= PORT_IF;
            cur_we     <= 1'b0;
            cur_word   <= 1'b0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            lo_byte    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
            if_ack     <= 1'b0;
            ls_ack     <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cur_port   <= cur_port_nxt;
            cur_we     <= cur_we_nxt;
            cur_word   <= cur_word_nxt;
            cur_addr   <= cur_addr_nxt;
            cur_wdata  <= cur_wdata_nxt;
            lo_byte    <= lo_byte_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            if_rdata   <= if_rdata_nxt;
            ls_rdata   <= ls_rdata_nxt;
            if_ack     <= if_ack_nxt;
            ls_ack     <= ls_ack_nxt;
        end
    end

    // With both ports requesting, round-robin favours the port that did not win last time.
    always_comb begin
        grant_ls = 1'b0;
        if (ls_req) begin
            if (!if_req || !RR_EN) begin
                grant_ls = 1'b1;
            end else begin
                grant_ls = (last_grant == PORT_IF);
            end
        end
    end

    assign cap_word = cur_word ? {mem_rdata, lo_byte} : {8'h00, mem_rdata};

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cur_port_nxt   = cur_port;
        cur_we_nxt     = cur_we;
        cur_word_nxt   = cur_word;
        cur_addr_nxt   = cur_addr;
        cur_wdata_nxt  = cur_wdata;
        lo_byte_nxt    = lo_byte;
        mem_en_nxt     = mem_en;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        if_rdata_nxt   = if_rdata;
        ls_rdata_nxt   = ls_rdata;
        if_ack_nxt     = 1'b0;
        ls_ack_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (if_req || ls_req) begin
                    last_grant_nxt = grant_ls ? PORT_LS : PORT_IF;
                    cur_port_nxt   = grant_ls ? PORT_LS : PORT_IF;
                    cur_we_nxt     = grant_ls ? ls_we : 1'b0;
                    cur_word_nxt   = grant_ls ? ls_word : 1'b1;
                    cur_addr_nxt   = grant_ls ? ls_addr : if_addr;
                    cur_wdata_nxt  = grant_ls ? ls_wdata : 16'h0000;
                    mem_en_nxt     = 1'b1;
                    mem_we_nxt     = grant_ls ? ls_we : 1'b0;
                    mem_addr_nxt   = grant_ls ? ls_addr : if_addr;
                    mem_wdata_nxt  = grant_ls ? ls_wdata[7:0] : 8'h00;
                    state_nxt      = PH0;
                end
            end
            PH0: begin
                if (cur_word) begin
                    mem_addr_nxt  = cur_addr + ADDR_W'(1);
                    mem_wdata_nxt = cur_wdata[15:8];
                    state_nxt     = PH1;
                end else begin
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                    state_nxt  = CAP;
                end
            end
            PH1: begin
                lo_byte_nxt = mem_rdata;
                mem_en_nxt  = 1'b0;
                mem_we_nxt  = 1'b0;
                state_nxt   = CAP;
            end
            CAP: begin
                if (cur_port == PORT_LS) begin
                    ls_rdata_nxt = cap_word;
                    ls_ack_nxt   = 1'b1;
                end else begin
                    if_rdata_nxt = cap_word;
                    if_ack_nxt   = 1'b1;
                end
                state_nxt = ACK;
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected acks, a monitor checks them.
module tb_mem_arbiter;

    localparam bit P_IF = 1'b0;
    localparam bit P_LS = 1'b1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req, if_ack;
    logic [15:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_word, ls_ack;
    logic [15:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_en, mem_we, busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic        b_reset;
    logic        b_if_req, b_if_ack;
    logic [15:0] b_if_addr, b_if_rdata;
    logic        b_ls_req, b_ls_we, b_ls_word, b_ls_ack;
    logic [15:0] b_ls_addr, b_ls_wdata, b_ls_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [15:0] b_mem_addr;
    logic [7:0]  b_mem_wdata, b_mem_rdata;
    assign b_mem_rdata = 8'h5A;

    mem_arbiter #(.ADDR_W(16), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .ls_req(ls_req), .ls_we(ls_we), .ls_word(ls_word), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ack(ls_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(16), .RR_EN(1'b0)) dut_fixed (
        .clk(clk), .reset(b_reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_word(b_ls_word), .ls_addr(b_ls_addr),
        .ls_wdata(b_ls_wdata), .ls_rdata(b_ls_rdata), .ls_ack(b_ls_ack),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Byte-wide synchronous memory: read data appears the cycle after the enable.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;
        bit          chk;
        logic [15:0] data;
        int          cycle;
    } exp_t;

    exp_t sb[$];
    exp_t sb_entry;
    int   checks = 0;
    int   errors = 0;
    int   b_ls_acks = 0;
    int   b_if_acks = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushExpected(input bit port, input bit chk, input logic [15:0] data, input int cycle);
        exp_t e;
        e.port  = port;
        e.chk   = chk;
        e.data  = data;
        e.cycle = cycle;
        sb.push_back(e);
    endtask

    // Called on a falling edge while the arbiter is idle; the next rising edge grants it.
    task automatic applyStimulus(input bit port, input bit we, input bit word,
                                 input logic [15:0] addr, input logic [15:0] wdata,
                                 input bit chk, input logic [15:0] exp_data);
        if (port == P_LS) begin
            ls_req   = 1'b1;
            ls_we    = we;
            ls_word  = word;
            ls_addr  = addr;
            ls_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
        pushExpected(port, chk, exp_data, cyc + ((port == P_IF || word) ? 4 : 3));
    endtask

    task automatic waitAck(input bit port);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = (port == P_LS) ? ls_ack : if_ack;
        end
        checkOutput(port ? "ls_ack_timeout" : "if_ack_timeout", {31'b0, seen}, 32'd1);
        @(negedge clk);
        if (port == P_LS) ls_req = 1'b0;
        else              if_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (if_ack || ls_ack) begin
            checkOutput("ack_collision", {31'b0, if_ack & ls_ack}, 32'd0);
            checkOutput("ack_expected", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                sb_entry = sb.pop_front();
                checkOutput("ack_port", {31'b0, ls_ack}, {31'b0, sb_entry.port});
                if (sb_entry.chk)
                    checkOutput(ls_ack ? "ls_rdata" : "if_rdata",
                                {16'h0, ls_ack ? ls_rdata : if_rdata}, {16'h0, sb_entry.data});
                checkOutput("ack_cycle", cyc, sb_entry.cycle);
            end
        end
    end

    always @(negedge clk) begin
        if (b_ls_ack) b_ls_acks <= b_ls_acks + 1;
        if (b_if_ack) b_if_acks <= b_if_acks + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;   if_req = 1'b0;   if_addr = '0;
        ls_req = 1'b0;  ls_we = 1'b0;    ls_word = 1'b0;  ls_addr = '0;  ls_wdata = '0;
        b_reset = 1'b1; b_if_req = 1'b0; b_if_addr = '0;
        b_ls_req = 1'b0; b_ls_we = 1'b0; b_ls_word = 1'b0; b_ls_addr = '0; b_ls_wdata = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy",     {31'b0, busy},     32'd0);
        checkOutput("rst_mem_en",   {31'b0, mem_en},   32'd0);
        checkOutput("rst_mem_we",   {31'b0, mem_we},   32'd0);
        checkOutput("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        checkOutput("rst_if_ack",   {31'b0, if_ack},   32'd0);
        checkOutput("rst_ls_ack",   {31'b0, ls_ack},   32'd0);
        checkOutput("rst_if_rdata", {16'b0, if_rdata}, 32'd0);
        checkOutput("rst_ls_rdata", {16'b0, ls_rdata}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] byte store / byte load");
        applyStimulus(P_LS, 1'b1, 1'b0, 16'h0100, 16'h12AB, 1'b0, 16'h0000);
        waitAck(P_LS);
        checkOutput("mem_0100", {24'b0, mem[16'h0100]}, 32'hAB);
        applyStimulus(P_LS, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h00AB);
        waitAck(P_LS);

        $display("[TB] word store / fetch");
        applyStimulus(P_LS, 1'b1, 1'b1, 16'h0400, 16'hBEEF, 1'b0, 16'h0000);
        waitAck(P_LS);
        checkOutput("mem_0400", {24'b0, mem[16'h0400]}, 32'hEF);
        checkOutput("mem_0401", {24'b0, mem[16'h0401]}, 32'hBE);
        applyStimulus(P_IF, 1'b0, 1'b1, 16'h0400, 16'h0000, 1'b1, 16'hBEEF);
        waitAck(P_IF);

        $display("[TB] word load across address wrap");
        applyStimulus(P_LS, 1'b1, 1'b0, 16'hFFFF, 16'h0034, 1'b0, 16'h0000);
        waitAck(P_LS);
        applyStimulus(P_LS, 1'b1, 1'b0, 16'h0000, 16'h0012, 1'b0, 16'h0000);
        waitAck(P_LS);
        applyStimulus(P_LS, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h1234);
        @(negedge clk);
        checkOutput("wrap_addr_lo", {16'b0, mem_addr}, 32'hFFFF);
        @(negedge clk);
        checkOutput("wrap_addr_hi", {16'b0, mem_addr}, 32'h0000);
        checkOutput("wrap_mem_en",  {31'b0, mem_en},   32'd1);
        waitAck(P_LS);
        applyStimulus(P_IF, 1'b0, 1'b1, 16'h0400, 16'h0000, 1'b1, 16'hBEEF);
        waitAck(P_IF);
        checkOutput("ls_rdata_hold", {16'b0, ls_rdata}, 32'h1234);

        $display("[TB] reset during word store");
        ls_req = 1'b1; ls_we = 1'b1; ls_word = 1'b1; ls_addr = 16'h0600; ls_wdata = 16'h5678;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_busy_ph1", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy",   {31'b0, busy},     32'd0);
        checkOutput("abort_mem_en", {31'b0, mem_en},   32'd0);
        checkOutput("abort_mem_we", {31'b0, mem_we},   32'd0);
        checkOutput("abort_ls_ack", {31'b0, ls_ack},   32'd0);
        checkOutput("abort_mem_lo", {24'b0, mem[16'h0600]}, 32'h78);
        reset = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_word = 1'b0;
        @(negedge clk);
        applyStimulus(P_IF, 1'b0, 1'b1, 16'h0400, 16'h0000, 1'b1, 16'hBEEF);
        waitAck(P_IF);

        $display("[TB] simultaneous requests, round-robin");
        reset = 1'b1;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_word = 1'b0; ls_addr = 16'h0100;
        if_req = 1'b1; if_addr = 16'h0400;
        reset = 1'b0;
        pushExpected(P_LS, 1'b1, 16'h00AB, cyc + 3);
        pushExpected(P_IF, 1'b1, 16'hBEEF, cyc + 8);
        pushExpected(P_LS, 1'b1, 16'h00AB, cyc + 12);
        repeat (12) @(negedge clk);
        ls_req = 1'b0; if_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] simultaneous requests, fixed priority");
        b_reset = 1'b0;
        b_ls_req = 1'b1; b_ls_addr = 16'h0010;
        b_if_req = 1'b1; b_if_addr = 16'h0020;
        repeat (20) @(negedge clk);
        checkOutput("fixed_ls_grants", b_ls_acks, 32'd5);
        checkOutput("fixed_if_grants", b_if_acks, 32'd0);
        b_ls_req = 1'b0; b_if_req = 1'b0; b_reset = 1'b1;

        repeat (5) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
